// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Brief    : Shares one combinational ALU and the z/v/n flag register
//            between the CPU execute stage (id 0) and the NN coprocessor
//            (id 1). One request is granted at a time, executed for one
//            cycle, and its result is held on a valid/ready response port.
//            Only CPU operations may update the flags.
// Option   : ALU_ARB_CPU_PRIO_EN - fixed CPU priority instead of round-robin
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
  parameter int              DATA_W   = 16,
  parameter int              OP_W     = 5,
  parameter logic [OP_W-1:0] FLAG_NOP = 5'h1F
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0 : CPU execute stage
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  // requester 1 : NN coprocessor
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  // shared combinational ALU
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ovfl,
  // flag register opcode
  output logic [OP_W-1:0]   flag_op,
  // response port
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [DATA_W-1:0] res_data,
  output logic              res_ovfl
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_last;      // id of the most recent grant
  logic                r_id;        // id of the transaction in flight
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;

  logic                r_res_valid;
  logic                r_res_id;
  logic [DATA_W-1:0]   r_res_data;
  logic                r_res_ovfl;

  logic                w_gnt_id;    // requester that would win in IDLE
  logic                w_accept;    // handshake with either requester

  // Grant selection between the two requesters (only meaningful in IDLE)
  always_comb begin
    w_gnt_id = 1'b0;
`ifdef ALU_ARB_CPU_PRIO_EN
    // CPU always wins; the coprocessor only gets the ALU when the CPU is idle
    w_gnt_id = ~r0_valid & r1_valid;
`else
    // On a tie the requester that was not served last wins
    if (r0_valid && r1_valid) begin
      w_gnt_id = ~r_last;
    end else begin
      w_gnt_id = r1_valid;
    end
`endif
  end

  assign w_accept = r0_ready | r1_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, requester readies and flag-register opcode
  always_comb begin
    w_next   = r_state;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    flag_op  = FLAG_NOP;
    case (r_state)
      S_IDLE: begin
        if (!rst && (r0_valid || r1_valid)) begin
          r0_ready = ~w_gnt_id;
          r1_ready = w_gnt_id;
          w_next   = S_EXEC;
        end
      end
      S_EXEC: begin
        // Coprocessor ops and aborted ops must leave the CPU flags untouched
        if (!rst && !r_id) begin
          flag_op = r_op;
        end
        w_next = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand latch on acceptance, result capture after the execute cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_op        <= FLAG_NOP;
      r_a         <= '0;
      r_b         <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_data  <= '0;
      r_res_ovfl  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_last <= w_gnt_id;
        r_id   <= w_gnt_id;
        r_op   <= w_gnt_id ? r1_op : r0_op;
        r_a    <= w_gnt_id ? r1_a  : r0_a;
        r_b    <= w_gnt_id ? r1_b  : r0_b;
      end
      if (r_state == S_EXEC) begin
        r_res_valid <= 1'b1;
        r_res_id    <= r_id;
        r_res_data  <= alu_out;
        r_res_ovfl  <= alu_ovfl;
      end
      if (r_state == S_RESP && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  // ALU inputs simply hold the last latched operands outside EXEC
  assign alu_op    = r_op;
  assign alu_a     = r_a;
  assign alu_b     = r_b;

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_data  = r_res_data;
  assign res_ovfl  = r_res_ovfl;

endmodule
`default_nettype wire
